// File: rtl/spi_gain_loader.sv
// SPI write/readback master for a daisy-chainable programmable preamp (mode 0).
// Shifts DATA_W bits out on spi_mosi while capturing the previous word on spi_miso.
module spi_gain_loader #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              load_ok,
  output logic [DATA_W-1:0] rd_data,
  output logic              amp_cs,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int PH_MAX = (CLK_DIV > CS_SETUP)
                          ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                          : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W = $clog2(PH_MAX + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, HOLD, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [DATA_W-1:0] tx_reg, tx_next;
  logic [DATA_W-1:0] rx_reg, rx_next;
  logic [DATA_W-1:0] rd_reg, rd_next;
  logic              armed_reg, armed_next;
  logic              busy_reg, busy_next;
  logic              cs_reg, cs_next;
  logic              sck_reg, sck_next;
  logic              mosi_reg, mosi_next;
  logic              ok_reg, ok_next;

  logic [DATA_W-1:0] tx_shift, rx_shift;
  logic              first_bit, next_bit, cnt_done;

  // Bit order only changes which end of the shift registers is used.
  assign tx_shift  = MSB_FIRST ? {tx_reg[DATA_W-2:0], 1'b0} : {1'b0, tx_reg[DATA_W-1:1]};
  assign rx_shift  = MSB_FIRST ? {rx_reg[DATA_W-2:0], spi_miso} : {spi_miso, rx_reg[DATA_W-1:1]};
  assign first_bit = MSB_FIRST ? data[DATA_W-1] : data[0];
  assign next_bit  = MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0];
  assign cnt_done  = (cnt_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      rd_reg    <= '0;
      armed_reg <= 1'b1;
      busy_reg  <= 1'b0;
      cs_reg    <= 1'b1;
      sck_reg   <= 1'b0;
      mosi_reg  <= 1'b0;
      ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      rd_reg    <= rd_next;
      armed_reg <= armed_next;
      busy_reg  <= busy_next;
      cs_reg    <= cs_next;
      sck_reg   <= sck_next;
      mosi_reg  <= mosi_next;
      ok_reg    <= ok_next;
    end
  end

  // Output registers are loaded with the value of the state being entered, so
  // every pin changes on the same edge as the state register.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    tx_next    = tx_reg;
    rx_next    = rx_reg;
    rd_next    = rd_reg;
    armed_next = load ? armed_reg : 1'b1;
    busy_next  = busy_reg;
    cs_next    = cs_reg;
    sck_next   = sck_reg;
    mosi_next  = mosi_reg;
    ok_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        cs_next   = 1'b1;
        sck_next  = 1'b0;
        mosi_next = 1'b0;
        if (load && armed_reg) begin
          armed_next = 1'b0;
          state_next = SETUP;
          cnt_next   = SETUP_LD;
          bit_next   = '0;
          tx_next    = data;
          rx_next    = '0;
          busy_next  = 1'b1;
          cs_next    = 1'b0;
          mosi_next  = first_bit;
        end
      end
      SETUP, LO: begin
        if (cnt_done) begin
          state_next = HI;
          cnt_next   = DIV_LD;
          sck_next   = 1'b1;
          rx_next    = rx_shift;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      HI: begin
        if (!cnt_done) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (bit_reg == LAST_BIT) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
          sck_next   = 1'b0;
        end else begin
          state_next = LO;
          cnt_next   = DIV_LD;
          sck_next   = 1'b0;
          bit_next   = bit_reg + BIT_W'(1);
          tx_next    = tx_shift;
          mosi_next  = next_bit;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_next = DONE;
          cs_next    = 1'b1;
          mosi_next  = 1'b0;
          ok_next    = 1'b1;
          rd_next    = rx_reg;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = busy_reg;
  assign load_ok  = ok_reg;
  assign rd_data  = rd_reg;
  assign amp_cs   = cs_reg;
  assign spi_sck  = sck_reg;
  assign spi_mosi = mosi_reg;

endmodule

// File: doc/spi_gain_loader.md
Name: spi_gain_loader

Overview:
- Parametrised SPI write/readback master for the programmable preamplifier (LTC6912-class) on the ADC front end; successor to the fixed 8-bit gain loader.
- Generalised over word width (daisy-chained amps), SCK divider, CS setup/hold and bit order.
- Captures the word shifted back on MISO, so the previous gain setting is read back on every write.
- Sits between the capture controller (issues load/data) and the board SPI pins.

Parameters:
- DATA_W, 8, shifted word width in bits (>=2; 16 for two chained amps).
- CLK_DIV, 2, clk cycles per SCK half-period (>=1).
- CS_SETUP, 2, clk cycles from amp_cs fall to first SCK rise (>=1).
- CS_HOLD, 2, clk cycles from last SCK fall to amp_cs rise (>=1).
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first (applies to both MOSI and MISO).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- load  in  1  transfer request, level-sensitive, edge-qualified (see Behaviour).
- data  in  DATA_W  word to send; sampled only in the accept cycle.
- busy  out  1  high from the cycle after accept until the load_ok cycle, inclusive.
- load_ok  out  1  one-cycle pulse, transfer complete.
- rd_data  out  DATA_W  word captured from spi_miso; updated in the load_ok cycle.
- amp_cs  out  1  chip select, active-low.
- spi_sck  out  1  SPI clock, mode 0 (idle low).
- spi_mosi  out  1  serial data to amp.
- spi_miso  in  1  serial data from amp (previous word).

Behaviour:
- Reset (async assert, sync release): amp_cs=1, spi_sck=0, spi_mosi=0, busy=0, load_ok=0, rd_data=0, armed=1, state=IDLE. Reset mid-transfer aborts immediately; no load_ok is generated and rd_data is cleared.
- Arming: accept requires load=1 in IDLE with armed=1. Accept clears armed. armed is set again only after a cycle with load=0. A load held high therefore yields exactly one transfer. load during busy is ignored, but a load=0 sample still re-arms.
- States:
  - IDLE: on accept, latch data into the shift register and go to SETUP.
  - SETUP: CS_SETUP cycles with amp_cs=0, sck=0 and mosi = first bit.
  - HI: CLK_DIV cycles with sck=1. spi_miso is sampled on the cycle sck rises.
  - LO: CLK_DIV cycles with sck=0. mosi advances to the next bit in the first LO cycle. LO goes back to HI.
  - HI of the last bit goes to HOLD.
  - HOLD: CS_HOLD cycles with sck=0 and mosi holding the last bit.
  - DONE: one cycle with amp_cs=1, load_ok=1, rd_data updated; busy still high. Then go to IDLE.
- amp_cs low duration: exactly CS_SETUP + (2*DATA_W-1)*CLK_DIV + CS_HOLD cycles (34 at defaults). Exactly DATA_W rising SCK edges per transfer.
- In IDLE: spi_mosi=0 and spi_sck=0. No glitches; all SPI outputs are registered.
- Bit order: MSB_FIRST=1 sends data[DATA_W-1] first and shifts MISO into the LSB; MSB_FIRST=0 mirrors this. rd_data bit i always equals amp bit i.
- Earliest next accept is the cycle after DONE, provided armed.
- Counters: a bit counter of width clog2(DATA_W+1) and a divider/phase counter sized for max(CLK_DIV, CS_SETUP, CS_HOLD). No wrap-around inside a transfer.

Test Plan:
- Reset held low with load=1 and random data → amp_cs=1, sck=0, mosi=0, busy=0, load_ok=0, rd_data=0, and no transfer starts. After release, a fresh load=1 starts a transfer.
- Defaults, data=8'hA4, load pulsed for 1 cycle:
  - mosi at the 8 rising SCK edges = 1,0,1,0,0,1,0,0.
  - amp_cs low for 34 cycles.
  - a single load_ok pulse in the cycle amp_cs rises.
- load held high for 12 cycles, then low, then high again → exactly two transfers, the second starting after the first's DONE. Changing data mid-transfer does not alter mosi.
- MISO model returning 8'h3C (MSB first, updated on SCK fall) while sending 8'h5A → rd_data=8'h3C at load_ok; on the next transfer sending 8'h11, rd_data=8'h5A with the model echoing the previous word.
- reset pulsed low after the 3rd SCK rise → outputs go to reset values within the same cycle, with no load_ok. The next load of 8'hA4 completes a full 34-cycle transfer.
- DATA_W=16, MSB_FIRST=0, CLK_DIV=3, data=16'h00A4 → 16 SCK rises with mosi sequence 0,0,1,0,0,1,0,1 followed by eight 0s. amp_cs low for 2+31*3+2=97 cycles.
